// File: rtl/dds_cfg_sequencer.sv
// DDS configuration sequencer: writes up to four 32-bit words to the DDS
// property registers over AXI4-Lite, reads each one back, and flags the first
// write-response error, read-response error or readback mismatch.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; error/err_idx keep the last result
// WREQ  | AW and W channels offered together, each dropped on its handshake
// WRESP | BREADY high, waiting for the write response
// RREQ  | AR channel offered for the current index
// RRESP | RREADY high, waiting for read data to compare
// FIN   | one-cycle done pulse, then back to IDLE
module dds_cfg_sequencer #(
    parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
    parameter int          C_NUM_REGS  = 4
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         start,
    input  logic [127:0] cfg_data,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [2:0]   err_idx,
    output logic [31:0]  M_AXI_AWADDR,
    output logic [2:0]   M_AXI_AWPROT,
    output logic         M_AXI_AWVALID,
    input  logic         M_AXI_AWREADY,
    output logic [31:0]  M_AXI_WDATA,
    output logic [3:0]   M_AXI_WSTRB,
    output logic         M_AXI_WVALID,
    input  logic         M_AXI_WREADY,
    input  logic [1:0]   M_AXI_BRESP,
    input  logic         M_AXI_BVALID,
    output logic         M_AXI_BREADY,
    output logic [31:0]  M_AXI_ARADDR,
    output logic [2:0]   M_AXI_ARPROT,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,
    input  logic [31:0]  M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RRESP, S_FIN
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(C_NUM_REGS - 1);

    state_t       state_q, state_d;
    logic [127:0] cfg_q, cfg_d;
    logic [1:0]   idx_q, idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic [2:0]   err_idx_q, err_idx_d;
    logic         awvalid_q, awvalid_d;
    logic         wvalid_q, wvalid_d;
    logic         aw_ok_q, aw_ok_d;
    logic         w_ok_q, w_ok_d;
    logic         bready_q, bready_d;
    logic         arvalid_q, arvalid_d;
    logic         rready_q, rready_d;

    logic [31:0]  cur_word;
    logic [31:0]  cur_addr;
    logic         aw_fin, w_fin;

    // Payloads come straight from the latched words and index, so they are
    // stable for as long as the matching valid is held.
    assign cur_word = cfg_q[{idx_q, 5'd0} +: 32];
    assign cur_addr = C_BASE_ADDR + {28'd0, idx_q, 2'b00};

    // A channel counts as finished once it has handshaken, now or earlier.
    assign aw_fin = aw_ok_q | (awvalid_q & M_AXI_AWREADY);
    assign w_fin  = w_ok_q  | (wvalid_q  & M_AXI_WREADY);

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d     = cfg_data;
                    error_d   = 1'b0;
                    err_idx_d = 3'd0;
                    idx_d     = 2'd0;
                    busy_d    = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    state_d   = S_WREQ;
                end
            end
            S_WREQ: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                aw_ok_d = aw_fin;
                w_ok_d  = w_fin;
                if (aw_fin && w_fin) begin
                    aw_ok_d  = 1'b0;
                    w_ok_d   = 1'b0;
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        error_d   = 1'b1;
                        err_idx_d = {1'b0, idx_q};
                        done_d    = 1'b1;
                        state_d   = S_FIN;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d     = 2'd0;
                        arvalid_d = 1'b1;
                        state_d   = S_RREQ;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WREQ;
                    end
                end
            end
            S_RREQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RRESP;
                end
            end
            S_RRESP: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != cur_word) begin
                        error_d   = 1'b1;
                        err_idx_d = {1'b1, idx_q};
                        done_d    = 1'b1;
                        state_d   = S_FIN;
                    end else if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        arvalid_d = 1'b1;
                        state_d   = S_RREQ;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_idx       = err_idx_q;
    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = cur_word;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = cur_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_dds_cfg_sequencer.sv
// Bench for dds_cfg_sequencer: an AXI4-Lite memory slave with knobs for AW
// delay, write-response error and corrupted readback, plus a scoreboard of
// the write and read addresses each sequence is expected to issue.
module tb_dds_cfg_sequencer;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, error;
    logic [2:0]   err_idx;
    logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]   M_AXI_WSTRB;
    logic         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic         M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic         M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]   M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0]  M_AXI_RDATA = '0;

    dds_cfg_sequencer dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scoreboard: {addr, data} per write, addr per read
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int          extra_wr = 0;
    int          extra_rd = 0;

    // slave knobs and state
    int          aw_hold = 1;
    int          bresp_bad_reg = -1;
    int          rdata_bad_reg = -1;
    logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
    logic [31:0] aw_addr_l = '0, w_data_l = '0, r_addr_l = '0;
    int          aw_cyc = 0, w_cyc = 0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
    logic [31:0] mem [4];
    logic [63:0] wr_exp;
    logic [31:0] rd_exp;

    // Slave: decisions made on the falling edge take effect at the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
            M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
            M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
            aw_got = 1'b0; w_got = 1'b0; r_pend = 1'b0; aw_cyc = 0; w_cyc = 0;
        end else begin
            if (M_AXI_AWVALID) aw_cyc++;
            if (M_AXI_WVALID)  w_cyc++;

            M_AXI_BVALID = 1'b0;
            M_AXI_BRESP  = 2'b00;
            if (aw_got && w_got && M_AXI_BREADY) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = (int'(aw_addr_l[3:2]) == bresp_bad_reg) ? 2'b10 : 2'b00;
                mem[aw_addr_l[3:2]] = w_data_l;
                if (exp_wr_q.size() > 0) begin
                    wr_exp = exp_wr_q.pop_front();
                    check_val("wr_addr_data", {aw_addr_l, w_data_l}, wr_exp);
                end else begin
                    extra_wr++;
                end
                check_val("awvalid_cycles", aw_cyc, aw_hold);
                check_val("wvalid_cycles", w_cyc, 1);
                aw_got = 1'b0; w_got = 1'b0; aw_cyc = 0; w_cyc = 0;
            end

            M_AXI_AWREADY = 1'b0;
            if (M_AXI_AWVALID && !aw_got && aw_cyc >= aw_hold) begin
                M_AXI_AWREADY = 1'b1;
                aw_got = 1'b1;
                aw_addr_l = M_AXI_AWADDR;
                aw_hs_cnt++;
            end
            M_AXI_WREADY = 1'b0;
            if (M_AXI_WVALID && !w_got) begin
                M_AXI_WREADY = 1'b1;
                w_got = 1'b1;
                w_data_l = M_AXI_WDATA;
                w_hs_cnt++;
            end

            M_AXI_RVALID = 1'b0;
            M_AXI_RRESP  = 2'b00;
            if (r_pend && M_AXI_RREADY) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = (int'(r_addr_l[3:2]) == rdata_bad_reg) ? 32'h0000_DEAD
                                                                      : mem[r_addr_l[3:2]];
                r_pend = 1'b0;
            end
            M_AXI_ARREADY = 1'b0;
            if (M_AXI_ARVALID && !r_pend) begin
                M_AXI_ARREADY = 1'b1;
                r_pend = 1'b1;
                r_addr_l = M_AXI_ARADDR;
                ar_hs_cnt++;
                if (exp_rd_q.size() > 0) begin
                    rd_exp = exp_rd_q.pop_front();
                    check_val("rd_addr", r_addr_l, rd_exp);
                end else begin
                    extra_rd++;
                end
            end
        end
    end

    task automatic push_expected(input logic [127:0] cfg, input int n_wr, input int n_rd);
        for (int i = 0; i < n_wr; i++) exp_wr_q.push_back({32'(4 * i), cfg[32 * i +: 32]});
        for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(32'(4 * i));
    endtask

    task automatic pulse_start(input logic [127:0] cfg);
        @(posedge ACLK); #1;
        start = 1'b1;
        cfg_data = cfg;
        @(posedge ACLK); #1;
        start = 1'b0;
    endtask

    // One full sequence; exp_lat is the cycle (1 = first after acceptance) of done.
    task automatic run_seq(input string name, input logic [127:0] cfg, input int n_wr,
                           input int n_rd, input logic exp_err, input logic [2:0] exp_idx,
                           input int exp_lat);
        int aw0, w0, ar0, ew0, er0, cyc;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; ar0 = ar_hs_cnt; ew0 = extra_wr; er0 = extra_rd;
        push_expected(cfg, n_wr, n_rd);
        pulse_start(cfg);
        @(negedge ACLK);
        check_val({name, "_busy_err_clr"}, {busy, error, err_idx}, {1'b1, 1'b0, 3'b000});
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge ACLK);
            cyc++;
        end
        check_val({name, "_done"}, done, 1'b1);
        check_val({name, "_latency"}, cyc, exp_lat);
        check_val({name, "_error"}, {error, err_idx}, {exp_err, exp_idx});
        @(negedge ACLK);
        check_val({name, "_busy_done_low"}, {busy, done}, 2'b00);
        repeat (3) @(negedge ACLK);
        check_val({name, "_sticky"}, {done, error, err_idx}, {1'b0, exp_err, exp_idx});
        check_val({name, "_wr_left"}, exp_wr_q.size() + extra_wr - ew0, 0);
        check_val({name, "_rd_left"}, exp_rd_q.size() + extra_rd - er0, 0);
        check_val({name, "_aw_count"}, aw_hs_cnt - aw0, n_wr);
        check_val({name, "_w_count"}, w_hs_cnt - w0, n_wr);
        check_val({name, "_ar_count"}, ar_hs_cnt - ar0, n_rd);
    endtask

    initial begin
        int k;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_val("reset_outputs",
                  {busy, done, error, err_idx, M_AXI_AWVALID, M_AXI_WVALID,
                   M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check_val("tie_offs", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, 10'h00F);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;

        // echoing slave, zero wait
        run_seq("basic", 128'h00000004_00000003_00000002_00000001, 4, 4, 1'b0, 3'b000, 17);

        // AW held off: AWVALID high for 3 cycles, WVALID for 1
        aw_hold = 3;
        run_seq("aw_delay", 128'hCAFE0004_5A5A0003_A5A50002_12340001, 4, 4, 1'b0, 3'b000, 25);
        aw_hold = 1;

        // write error on register 2: no reads issued
        bresp_bad_reg = 2;
        run_seq("bresp_err", 128'h44444444_33333333_22222222_11111111, 3, 0, 1'b1, 3'b010, 7);
        bresp_bad_reg = -1;

        // readback mismatch on register 3
        rdata_bad_reg = 3;
        run_seq("rd_mismatch", 128'h0BADF00D_76543210_FEDCBA98_01234567, 4, 4, 1'b1, 3'b111, 17);
        rdata_bad_reg = -1;

        // second start while busy is ignored, then reset during RRESP
        push_expected(128'h00000040_00000030_00000020_00000010, 4, 4);
        pulse_start(128'h00000040_00000030_00000020_00000010);
        repeat (2) @(posedge ACLK);
        pulse_start(128'hFFFF0004_FFFF0003_FFFF0002_FFFF0001);
        k = 0;
        @(negedge ACLK);
        while (!M_AXI_ARVALID && k < 200) begin
            @(negedge ACLK);
            k++;
        end
        check_val("arvalid_seen", M_AXI_ARVALID, 1'b1);
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        @(negedge ACLK);
        check_val("in_rresp_before_reset", {busy, M_AXI_RREADY}, 2'b11);
        check_val("queues_before_reset", {32'(exp_wr_q.size()), 32'(exp_rd_q.size())},
                  {32'd0, 32'd3});
        @(posedge ACLK);
        @(negedge ACLK);
        check_val("outputs_after_reset",
                  {busy, done, error, err_idx, M_AXI_AWVALID, M_AXI_WVALID,
                   M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        run_seq("after_reset", 128'h89ABCDEF_13579BDF_2468ACE0_0F0F0F0F, 4, 4, 1'b0, 3'b000, 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
